wave_ctrl: RTL

Register and wave-RAM controller for the wave channel. It decodes CPU bus accesses to NR30–NR34 (FF1A–FF1E) and wave RAM (FF30–FF3F), and holds the channel configuration fields. It issues the one-cycle trigger pulse and owns the 16x8 wave RAM. A single RAM port is shared between CPU accesses and playback sample fetches through a fair two-requester arbiter.

---
 rtl/wave_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/wave_ctrl.sv
// Wave channel register block and wave-RAM controller.
// Decodes CPU accesses to NR30..NR34 and the 16-byte wave RAM, holds the
// channel configuration, issues the trigger pulse and shares one RAM port
// between CPU accesses and playback fetches through a round-robin arbiter.
//
// Handshake: a requester raises *_req and holds it (with its address/data
// stable) until the matching *_ack pulse. The ack pulses for one cycle, two
// cycles after the request is seen in IDLE; the requester drops its req in
// the cycle after the ack. A req still high during its own ack cycle is
// ignored by the arbiter.
module wave_ctrl #(
    parameter logic [10:0] RESET_FREQ  = 11'd0,
    parameter bit          CPU_LOCKOUT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        play_req,
    input  logic [4:0]  play_pos,
    output logic        play_ack,
    output logic [3:0]  play_sample,
    input  logic        chan_active,
    output logic        dac_en,
    output logic [1:0]  vol,
    output logic [7:0]  len_load,
    output logic        len_enable,
    output logic [10:0] freq,
    output logic        trigger,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT_CPU  = 2'd1,
        GRANT_PLAY = 2'd2
    } arb_state_t;

    // last_grant encoding: 0 = PLAY, 1 = CPU
    localparam logic LG_PLAY = 1'b0;
    localparam logic LG_CPU  = 1'b1;

    arb_state_t  state_q;
    logic        last_grant_q;
    logic        cpu_ack_q;
    logic        play_ack_q;
    logic [7:0]  cpu_rdata_q;
    logic [3:0]  play_sample_q;
    logic [3:0]  play_byte_q;
    logic        dac_en_q;
    logic [1:0]  vol_q;
    logic [7:0]  len_load_q;
    logic        len_enable_q;
    logic [10:0] freq_q;
    logic        trigger_q;

    logic [7:0]  wave_mem [16];

    logic        cpu_go;
    logic        play_go;
    logic        wave_hit;
    logic [3:0]  cpu_byte;
    logic [7:0]  play_byte;
    logic [3:0]  play_sample_d;
    logic [7:0]  rdata_d;

    // Request qualification, address redirection and read-data mux
    always_comb begin
        cpu_go   = cpu_req && !cpu_ack_q;
        play_go  = play_req && !play_ack_q;
        wave_hit = (cpu_addr[7:4] == 4'h3);
        // While the channel plays, the CPU only reaches the byte being played
        cpu_byte = ((CPU_LOCKOUT != 1'b0) && chan_active) ? play_byte_q : cpu_addr[3:0];
        play_byte = wave_mem[play_pos[4:1]];
        // Even samples live in the high nibble
        play_sample_d = play_pos[0] ? play_byte[3:0] : play_byte[7:4];
        rdata_d = 8'hFF;
        if (wave_hit) begin
            rdata_d = wave_mem[cpu_byte];
        end else begin
            case (cpu_addr)
                8'h1A:   rdata_d = {dac_en_q, 7'h7F};
                8'h1C:   rdata_d = {1'b1, vol_q, 5'h1F};
                8'h1E:   rdata_d = {1'b1, len_enable_q, 6'h3F};
                default: rdata_d = 8'hFF;
            endcase
        end
    end

    // Wave RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (!reset && state_q == GRANT_CPU && cpu_we && wave_hit) begin
            wave_mem[cpu_byte] <= cpu_wdata;
        end
    end

    // Arbiter FSM with register file, acks and trigger pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            last_grant_q  <= LG_PLAY;
            cpu_ack_q     <= 1'b0;
            play_ack_q    <= 1'b0;
            cpu_rdata_q   <= 8'h00;
            play_sample_q <= 4'h0;
            play_byte_q   <= 4'h0;
            dac_en_q      <= 1'b0;
            vol_q         <= 2'b00;
            len_load_q    <= 8'h00;
            len_enable_q  <= 1'b0;
            freq_q        <= RESET_FREQ;
            trigger_q     <= 1'b0;
        end else begin
            cpu_ack_q  <= 1'b0;
            play_ack_q <= 1'b0;
            trigger_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu_go && (!play_go || last_grant_q == LG_PLAY)) begin
                        state_q <= GRANT_CPU;
                    end else if (play_go) begin
                        state_q <= GRANT_PLAY;
                    end
                end
                GRANT_CPU: begin
                    state_q      <= IDLE;
                    last_grant_q <= LG_CPU;
                    cpu_ack_q    <= 1'b1;
                    cpu_rdata_q  <= rdata_d;
                    if (cpu_we && !wave_hit) begin
                        case (cpu_addr)
                            8'h1A: dac_en_q   <= cpu_wdata[7];
                            8'h1B: len_load_q <= cpu_wdata;
                            8'h1C: vol_q      <= cpu_wdata[6:5];
                            8'h1D: freq_q[7:0] <= cpu_wdata;
                            8'h1E: begin
                                freq_q[10:8] <= cpu_wdata[2:0];
                                len_enable_q <= cpu_wdata[6];
                                trigger_q    <= cpu_wdata[7] & dac_en_q;
                            end
                            default: ;
                        endcase
                    end
                end
                GRANT_PLAY: begin
                    state_q       <= IDLE;
                    last_grant_q  <= LG_PLAY;
                    play_ack_q    <= 1'b1;
                    play_sample_q <= play_sample_d;
                    play_byte_q   <= play_pos[4:1];
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_ack     = cpu_ack_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign play_ack    = play_ack_q;
    assign play_sample = play_sample_q;
    assign dac_en      = dac_en_q;
    assign vol         = vol_q;
    assign len_load    = len_load_q;
    assign len_enable  = len_enable_q;
    assign freq        = freq_q;
    assign trigger     = trigger_q;
    assign dbg_state   = state_q;

endmodule
